mips_multicycle: RTL
====================

# mips_multicycle

Multi-cycle MIPS-subset core, the successor to the single-cycle top level. It replaces the combinational fetch–execute path with an FSM-sequenced datapath. One unified memory port with a req/ready handshake serves instruction fetch and data access and tolerates arbitrary wait states. The core adds taken branches, lui, a configurable reset vector, a bus-timeout watchdog, and a halt state that reports its cause.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded on reset; must be word-aligned.
- BUS_TIMEOUT, 0: maximum number of cycles a memory request may wait for mem_ready; 0 disables the watchdog.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset, asynchronous and active-low.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write, 0 = read; qualified by mem_req.
- mem_addr  out  32  byte address; always word-aligned when mem_req=1.
- mem_wdata  out  32  store data.
- mem_ready  in  1  transfer completes at a rising edge where mem_req=1 and mem_ready=1.
- mem_rdata  in  32  read data; valid in the mem_ready cycle.
- retire  out  1  one-cycle pulse in the final cycle of each completed instruction.
- pc_out  out  32  address of the instruction currently in flight.
- halt  out  1  core stopped.
- halt_cause  out  2  0 none, 1 illegal instruction, 2 misaligned data address, 3 bus timeout.

## Operation
- **Supported opcodes (hex):**
  - R-type (op 00) with funct 20 add, 22 sub, 24 and, 25 or, 2A slt.
  - 08 addi, 0A slti, 0C andi, 0D ori, 0F lui.
  - 23 lw, 2B sw, 04 beq, 05 bne, 02 j.
  - Any other opcode or funct goes to HALT with cause 1.
- **Arithmetic:**
  - 32-bit, wrap-around, no overflow trap.
  - slt/slti compare signed.
  - addi/slti/lw/sw/branches sign-extend imm16; andi/ori zero-extend.
  - lui writes {imm16, 16'h0}.
- **Branch and jump targets:**
  - Branch target = PC+4 + (sext(imm16)<<2), mod 2^32.
  - Jump target = {PC+4[31:28], idx26, 2'b00}.
- **Register file:**
  - 32×32, two read ports, one write port; r0 reads 0 and writes to it are discarded.
  - Asynchronous reset clears all registers to 0.
  - Destination is rd for R-type and rt for immediate forms and lw.
- **FSM states:**
  - **FETCH:** mem_req=1, mem_we=0, mem_addr=PC. On ready, latch IR and PC<=PC+4. Go to DECODE.
  - **DECODE:** latch A=rs and B=rt; precompute the branch target. Illegal instruction goes to HALT(1); otherwise go to EXEC.
  - **EXEC, ALU ops:** ALUOut<=result, go to WB.
  - **EXEC, lw/sw:** ALUOut<=A+sext. A misaligned address (low 2 bits ≠ 0) goes to HALT(2) with no memory access; otherwise go to MEM.
  - **EXEC, beq/bne/j:** update PC if taken, retire, go to FETCH.
  - **MEM:**
    - lw: read at ALUOut; on ready latch MDR and go to WB.
    - sw: write B at ALUOut; on ready retire and go to FETCH.
  - **WB:** write ALUOut or MDR to the destination register, retire, go to FETCH.
  - **HALT:** terminal; mem_req=0 and halt=1 until reset.
- **Watchdog:** the counter clears on every new request. If BUS_TIMEOUT≠0 and mem_ready stays low for BUS_TIMEOUT cycles in FETCH/MEM, go to HALT(3); the request is abandoned.
- **pc_out:** holds the fetch address of the current instruction, including while in HALT.

## Timing
- **Reset values:** mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, retire=0, halt=0, halt_cause=0, pc_out=RESET_PC, state=FETCH.
- **First request:** mem_req rises in the first cycle after rst_n deasserts.
- **Reset mid-operation:** rst_n assertion takes effect immediately, in any state, including mid-handshake; mem_req drops asynchronously.
- **Handshake stability:**
  - While mem_req=1 and mem_ready=0, mem_addr, mem_we and mem_wdata are stable.
  - mem_ready while mem_req=0 is ignored.
  - Exactly one transfer occurs per request.
- **Back-to-back requests:** allowed (sw MEM → FETCH); mem_req stays high and address/we change after the completing edge.
- **Latency with zero wait states** (ready in the request cycle):
  - R-type/imm 4 cycles, lw 5, sw 4, beq/bne/j 3.
  - Each wait cycle adds 1.
- **retire:** high in the WB cycle, the sw MEM ready cycle, or the branch/jump EXEC cycle; never in HALT.

## Structure
- **Package mips_mc_pkg:** opcode and funct localparams, the state enum, and the halt_cause encodings.
- **Sub-module mips_regfile:** 32×32, two asynchronous read ports, one synchronous write port, r0 forced to zero, async active-low clear.
- **Top level:** the FSM, datapath registers (PC, IR, A, B, ALUOut, MDR), ALU and watchdog are written inline.

## Test plan
- **Reset vector:** RESET_PC=32'h100; release rst_n → next cycle mem_req=1, mem_we=0, mem_addr=32'h100.
- **ALU program:** addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; slt r4,r2,r1; lui r6,0x1234 → r3=2, r4=1, r6=32'h1234_0000; 4 cycles per instruction with zero wait.
- **Memory with wait states:** sw r3,8(r0) then lw r5,8(r0), mem_ready delayed 3 cycles → exactly one write (addr 8, data 2) with stable outputs; r5=2; lw takes 8 cycles.
- **Branches and jump:**
  - beq r1,r1,+2 → PC skips two instructions.
  - bne r1,r1 → falls through.
  - beq r0,r0,-1 → loops at the same address.
  - j 0x40 → next fetch address 0x100.
- **Halts:**
  - Opcode 3F at 0x10 → halt=1, halt_cause=1, pc_out=0x10, no further mem_req.
  - lw r1,6(r0) → halt_cause=2, no data request.
- **Timeout and reset:**
  - BUS_TIMEOUT=8 with mem_ready held low → halt_cause=3 after 8 wait cycles.
  - rst_n low mid-MEM → mem_req=0 immediately; refetch from RESET_PC after release.

Source files
------------

// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset core:
// opcodes, functs, FSM states and halt causes.
package mips_mc_pkg;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_BNE  = 6'h05;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_SLTI = 6'h0A;
   localparam logic [5:0] OP_ANDI = 6'h0C;
   localparam logic [5:0] OP_ORI  = 6'h0D;
   localparam logic [5:0] OP_LUI  = 6'h0F;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;

   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_SLT  = 6'h2A;

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   typedef enum logic [1:0] {
      HC_NONE     = 2'd0,
      HC_ILLEGAL  = 2'd1,
      HC_MISALIGN = 2'd2,
      HC_TIMEOUT  = 2'd3
   } halt_cause_t;

   function automatic logic is_legal(logic [5:0] op, logic [5:0] fn);
      case (op)
         OP_R:
            return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
         OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI,
         OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW:
            return 1'b1;
         default:
            return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two async read ports, one sync write port,
// r0 hard-wired to zero, async active-low clear.
module mips_regfile (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   input  logic        we,
   input  logic [4:0]  wa,
   input  logic [31:0] wd,
   output logic [31:0] rd1,
   output logic [31:0] rd2
);

   logic [31:0] regs [0:31];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (we && wa != 5'd0) begin
         regs[wa] <= wd;
      end
   end

   assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
   assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];

endmodule

// File: rtl/mips_multicycle.sv
// Multi-cycle MIPS-subset core with one shared req/ready memory
// port, bus watchdog and a terminal halt state with cause.
module mips_multicycle
   import mips_mc_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned BUS_TIMEOUT = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        retire,
   output logic [31:0] pc_out,
   output logic        halt,
   output logic [1:0]  halt_cause
);

   localparam logic [31:0] TO_LIM = 32'(BUS_TIMEOUT) - 32'd1;

   state_t      state;
   halt_cause_t cause;
   logic [31:0] pc, ir, a, b, alu_out, mdr, wdog;

   logic [5:0]  op, fn;
   logic [4:0]  rs, rt, rd;
   logic [31:0] sext, zext, opb, alu_res;
   logic [31:0] rf1, rf2, pc_next;
   logic        is_r, is_lw, is_sw, is_br, taken;
   logic        xfer, timeout;

   assign op   = ir[31:26];
   assign rs   = ir[25:21];
   assign rt   = ir[20:16];
   assign rd   = ir[15:11];
   assign fn   = ir[5:0];
   assign sext = {{16{ir[15]}}, ir[15:0]};
   assign zext = {16'h0, ir[15:0]};

   assign is_r  = (op == OP_R);
   assign is_lw = (op == OP_LW);
   assign is_sw = (op == OP_SW);
   assign is_br = (op == OP_BEQ) || (op == OP_BNE) || (op == OP_J);

   assign taken = (op == OP_J)
               || (op == OP_BEQ && a == b)
               || (op == OP_BNE && a != b);
   assign pc_next = taken ? alu_out : pc;

   always_comb begin
      opb = is_r ? b : sext;
      if (op == OP_ANDI || op == OP_ORI) opb = zext;
      unique case (1'b1)
         op == OP_LUI:
            alu_res = {ir[15:0], 16'h0};
         op == OP_ANDI, is_r && fn == FN_AND:
            alu_res = a & opb;
         op == OP_ORI, is_r && fn == FN_OR:
            alu_res = a | opb;
         op == OP_SLTI, is_r && fn == FN_SLT:
            alu_res = {31'b0, $signed(a) < $signed(opb)};
         is_r && fn == FN_SUB:
            alu_res = a - opb;
         default:
            alu_res = a + opb;
      endcase
   end

   mips_regfile u_rf (
      .clk   (clk),
      .rst_n (rst_n),
      .ra1   (rs),
      .ra2   (rt),
      .we    (state == S_WB),
      .wa    (is_r ? rd : rt),
      .wd    (is_lw ? mdr : alu_out),
      .rd1   (rf1),
      .rd2   (rf2)
   );

   assign xfer    = mem_req && mem_ready;
   assign timeout = (BUS_TIMEOUT != 0) && mem_req
                 && !mem_ready && (wdog == TO_LIM);

   assign retire = (state == S_WB)
                || (state == S_EXEC && is_br)
                || (state == S_MEM && is_sw && xfer);
   assign halt_cause = cause;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_FETCH;
         cause     <= HC_NONE;
         halt      <= 1'b0;
         pc        <= RESET_PC;
         pc_out    <= RESET_PC;
         ir        <= '0;
         a         <= '0;
         b         <= '0;
         alu_out   <= '0;
         mdr       <= '0;
         wdog      <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else if (timeout) begin
         mem_req <= 1'b0;
         halt    <= 1'b1;
         cause   <= HC_TIMEOUT;
         state   <= S_HALT;
      end else begin
         if (mem_req && !mem_ready) wdog <= wdog + 32'd1;
         unique case (state)
            S_FETCH: begin
               // Only the very first fetch after reset arrives idle.
               if (!mem_req) begin
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= pc;
                  wdog     <= '0;
               end else if (mem_ready) begin
                  ir      <= mem_rdata;
                  pc      <= pc + 32'd4;
                  mem_req <= 1'b0;
                  state   <= S_DECODE;
               end
            end
            S_DECODE: begin
               a <= rf1;
               b <= rf2;
               alu_out <= (op == OP_J)
                  ? {pc[31:28], ir[25:0], 2'b00}
                  : pc + {sext[29:0], 2'b00};
               if (!is_legal(op, fn)) begin
                  halt  <= 1'b1;
                  cause <= HC_ILLEGAL;
                  state <= S_HALT;
               end else begin
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (is_br) begin
                  pc       <= pc_next;
                  pc_out   <= pc_next;
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= pc_next;
                  wdog     <= '0;
                  state    <= S_FETCH;
               end else if (is_lw || is_sw) begin
                  alu_out <= alu_res;
                  if (alu_res[1:0] != 2'b00) begin
                     halt  <= 1'b1;
                     cause <= HC_MISALIGN;
                     state <= S_HALT;
                  end else begin
                     mem_req   <= 1'b1;
                     mem_we    <= is_sw;
                     mem_addr  <= alu_res;
                     mem_wdata <= b;
                     wdog      <= '0;
                     state     <= S_MEM;
                  end
               end else begin
                  alu_out <= alu_res;
                  state   <= S_WB;
               end
            end
            S_MEM: begin
               if (xfer) begin
                  mdr <= mem_rdata;
                  if (is_sw) begin
                     mem_we   <= 1'b0;
                     mem_addr <= pc;
                     pc_out   <= pc;
                     wdog     <= '0;
                     state    <= S_FETCH;
                  end else begin
                     mem_req <= 1'b0;
                     state   <= S_WB;
                  end
               end
            end
            S_WB: begin
               mem_req  <= 1'b1;
               mem_we   <= 1'b0;
               mem_addr <= pc;
               pc_out   <= pc;
               wdog     <= '0;
               state    <= S_FETCH;
            end
            default: ;
         endcase
      end
   end

endmodule
